// File: rtl/safe_lockout_ctrl.sv
// Attempt-outcome controller for the digital safe: timed door release,
// consecutive-failure counting, timed lockout and a sticky alarm.
module safe_lockout_ctrl #(
  parameter int MAX_FAIL    = 3,
  parameter int OPEN_CYCLES = 16,
  parameter int LOCK_CYCLES = 64,
  parameter int CW          = $clog2(MAX_FAIL + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          unlock_valid,
  input  logic          unlock,
  input  logic          incorrect,
  input  logic          alarm_ack,
  output logic          door_open,
  output logic          locked_out,
  output logic          alarm,
  output logic          entry_en,
  output logic [CW-1:0] fail_count
);

  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] FAIL_LAST = CW'(MAX_FAIL - 1);
  localparam logic [CW-1:0] FAIL_MAX  = CW'(MAX_FAIL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tmr;
  logic [CW-1:0] r_fail_count;
  logic          r_door_open;
  logic          r_locked_out;
  logic          r_alarm;
  logic          r_entry_en;

  // Anything that is not a clean match counts as a failure.
  logic w_success;
  assign w_success = unlock & ~incorrect;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_tmr        <= '0;
      r_fail_count <= '0;
      r_door_open  <= 1'b0;
      r_locked_out <= 1'b0;
      r_alarm      <= 1'b0;
      r_entry_en   <= 1'b1;
    end else begin
      // The lockout-entry set below overrides a same-cycle acknowledge.
      if (alarm_ack) begin
        r_alarm <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (unlock_valid) begin
            if (w_success) begin
              r_state      <= OPEN;
              r_tmr        <= OPEN_LOAD;
              r_fail_count <= '0;
              r_door_open  <= 1'b1;
              r_entry_en   <= 1'b0;
            end else if (r_fail_count >= FAIL_LAST) begin
              r_state      <= LOCKOUT;
              r_tmr        <= LOCK_LOAD;
              r_fail_count <= FAIL_MAX;
              r_locked_out <= 1'b1;
              r_alarm      <= 1'b1;
              r_entry_en   <= 1'b0;
            end else begin
              r_fail_count <= r_fail_count + CW'(1);
            end
          end
        end

        OPEN: begin
          if (r_tmr == '0) begin
            r_state     <= IDLE;
            r_door_open <= 1'b0;
            r_entry_en  <= 1'b1;
          end else begin
            r_tmr <= r_tmr - TW'(1);
          end
        end

        LOCKOUT: begin
          if (r_tmr == '0) begin
            r_state      <= IDLE;
            r_fail_count <= '0;
            r_locked_out <= 1'b0;
            r_entry_en   <= 1'b1;
          end else begin
            r_tmr <= r_tmr - TW'(1);
          end
        end

        default: begin
          r_state      <= IDLE;
          r_tmr        <= '0;
          r_door_open  <= 1'b0;
          r_locked_out <= 1'b0;
          r_entry_en   <= 1'b1;
        end
      endcase
    end
  end

  assign door_open  = r_door_open;
  assign locked_out = r_locked_out;
  assign alarm      = r_alarm;
  assign entry_en   = r_entry_en;
  assign fail_count = r_fail_count;

endmodule
